// File: rtl/ram_write_arbiter_pkg.sv
// Shared definitions for the RAM write arbiter: FSM encoding, default ring
// placement (ROM programs must agree on these) and bus widths.
package ram_write_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR_CODE = 2'd1,
        WR_HEAD = 2'd2
    } arb_state_t;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 16;
    localparam int CODE_W = 8;

    localparam logic [ADDR_W-1:0] RING_BASE_DEFAULT = 8'hF0;
    localparam logic [ADDR_W-1:0] HEAD_ADDR_DEFAULT = 8'hF8;

endpackage

// File: rtl/ram_write_arbiter_if.sv
// Bus bundle between the ALU/keyboard requesters and the RAM write port.
interface ram_write_arbiter_if;

    logic                                      iAluWriteEnable;
    logic [ram_write_arbiter_pkg::ADDR_W-1:0]  iAluWriteAddress;
    logic [ram_write_arbiter_pkg::DATA_W-1:0]  iAluDataIn;
    logic                                      iKeyValid;
    logic [ram_write_arbiter_pkg::CODE_W-1:0]  iKeyCode;
    logic                                      oWriteEnable;
    logic [ram_write_arbiter_pkg::ADDR_W-1:0]  oWriteAddress;
    logic [ram_write_arbiter_pkg::DATA_W-1:0]  oDataOut;
    logic                                      oKeyPending;
    logic                                      oOverflow;
    logic                                      oStarved;

    modport master (
        output iAluWriteEnable, iAluWriteAddress, iAluDataIn, iKeyValid, iKeyCode,
        input  oWriteEnable, oWriteAddress, oDataOut, oKeyPending, oOverflow, oStarved
    );

    modport slave (
        input  iAluWriteEnable, iAluWriteAddress, iAluDataIn, iKeyValid, iKeyCode,
        output oWriteEnable, oWriteAddress, oDataOut, oKeyPending, oOverflow, oStarved
    );

endinterface

// File: rtl/ram_write_arbiter_scancode_fifo.sv
// Small scancode FIFO; a push while full is accepted only when a pop frees
// a slot in the same cycle.
module scancode_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              empty,
    output logic              full
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W:0]    count;
    logic              push_ok;
    logic              pop_ok;

    assign empty   = (count == '0);
    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/ram_write_arbiter.sv
// Shares the RAM write port between ALU writeback (always wins) and the
// keyboard path, which commits each scancode to a ring and then the head word.
module ram_write_arbiter
    import ram_write_arbiter_pkg::*;
#(
    parameter int                FIFO_DEPTH   = 4,
    parameter logic [ADDR_W-1:0] RING_BASE    = RING_BASE_DEFAULT,
    parameter int                RING_LOG2    = 3,
    parameter logic [ADDR_W-1:0] HEAD_ADDR    = HEAD_ADDR_DEFAULT,
    parameter int                STARVE_LIMIT = 16
) (
    input logic                Clock,
    input logic                Reset,
    ram_write_arbiter_if.slave bus
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    arb_state_t           state;
    logic [RING_LOG2-1:0] wr_ptr;
    logic [RING_LOG2-1:0] wr_ptr_inc;
    logic [CNT_W-1:0]     starve_cnt;
    logic                 key_pending;
    logic                 overflow;
    logic                 starved;
    logic                 key_req;
    logic                 grant;
    logic                 denied;
    logic                 pop;
    logic [CODE_W-1:0]    fifo_dout;
    logic                 fifo_empty;
    logic                 fifo_full;
    logic [ADDR_W-1:0]    ring_addr;
    logic [DATA_W-1:0]    head_word;

    assign key_req    = (state != IDLE);
    assign grant      = key_req && !bus.iAluWriteEnable && !Reset;
    assign denied     = key_req && bus.iAluWriteEnable;
    assign pop        = grant && (state == WR_CODE);
    assign wr_ptr_inc = wr_ptr + RING_LOG2'(1);
    assign ring_addr  = RING_BASE + ADDR_W'(wr_ptr);
    assign head_word  = {{(DATA_W-RING_LOG2){1'b0}}, wr_ptr_inc};

    scancode_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .DATA_W (CODE_W)
    ) u_fifo (
        .clk   (Clock),
        .rst   (Reset),
        .push  (bus.iKeyValid),
        .pop   (pop),
        .din   (bus.iKeyCode),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    always_comb begin
        bus.oWriteEnable  = 1'b0;
        bus.oWriteAddress = '0;
        bus.oDataOut      = '0;
        if (bus.iAluWriteEnable) begin
            bus.oWriteEnable  = 1'b1;
            bus.oWriteAddress = bus.iAluWriteAddress;
            bus.oDataOut      = bus.iAluDataIn;
        end else if (grant) begin
            bus.oWriteEnable = 1'b1;
            if (state == WR_CODE) begin
                bus.oWriteAddress = ring_addr;
                bus.oDataOut      = {{(DATA_W-CODE_W){1'b0}}, fifo_dout};
            end else begin
                bus.oWriteAddress = HEAD_ADDR;
                bus.oDataOut      = head_word;
            end
        end
    end

    // Pending is registered from the next state: when returning to IDLE only
    // a same-cycle push can leave the FIFO non-empty.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            starve_cnt  <= '0;
            key_pending <= 1'b0;
            overflow    <= 1'b0;
            starved     <= 1'b0;
        end else begin
            key_pending <= 1'b1;
            case (state)
                IDLE: begin
                    if (!fifo_empty) state <= WR_CODE;
                    else             key_pending <= bus.iKeyValid;
                end
                WR_CODE: begin
                    if (grant) state <= WR_HEAD;
                end
                WR_HEAD: begin
                    if (grant) begin
                        wr_ptr <= wr_ptr_inc;
                        if (fifo_empty) begin
                            state       <= IDLE;
                            key_pending <= bus.iKeyValid;
                        end else begin
                            state <= WR_CODE;
                        end
                    end
                end
                default: begin
                    state       <= IDLE;
                    key_pending <= bus.iKeyValid;
                end
            endcase

            if (grant) begin
                starve_cnt <= '0;
            end else if (denied && (starve_cnt != CNT_W'(STARVE_LIMIT))) begin
                starve_cnt <= starve_cnt + CNT_W'(1);
                if (starve_cnt == CNT_W'(STARVE_LIMIT - 1)) starved <= 1'b1;
            end

            if (bus.iKeyValid && fifo_full && !pop) overflow <= 1'b1;
        end
    end

    assign bus.oKeyPending = key_pending;
    assign bus.oOverflow   = overflow;
    assign bus.oStarved    = starved;

endmodule

// File: tb/tb_ram_write_arbiter.sv
// Scoreboard bench: a queue-based model predicts the RAM write port and the
// status flags every cycle; a negedge monitor compares against the DUT.
module tb_ram_write_arbiter;

    localparam int          DEPTH = 4;
    localparam logic [7:0]  BASE  = 8'hF0;
    localparam int          RING  = 8;
    localparam logic [7:0]  HEAD  = 8'hF8;
    localparam int          LIMIT = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ram_write_arbiter_if bus();

    ram_write_arbiter #(
        .FIFO_DEPTH   (DEPTH),
        .RING_BASE    (BASE),
        .RING_LOG2    (3),
        .HEAD_ADDR    (HEAD),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .Clock (clk),
        .Reset (rst),
        .bus   (bus)
    );

    typedef struct {
        bit          we;
        logic [7:0]  addr;
        logic [15:0] data;
        bit          pend;
        bit          ovf;
        bit          stv;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    // Reference model state: pending codes, engine activity and ring position.
    logic [7:0] mq[$];
    bit m_busy = 0, m_head = 0, m_ovf = 0, m_stv = 0, m_pend = 0;
    int m_ptr = 0, m_cnt = 0;

    task automatic cycle(input bit r, input bit awe, input logic [7:0] aa,
                         input logic [15:0] ad, input bit kv, input logic [7:0] kc);
        exp_t e;
        bit   granted, nb, nh;
        @(posedge clk);
        #1;
        rst                  = r;
        bus.iAluWriteEnable  = awe;
        bus.iAluWriteAddress = aa;
        bus.iAluDataIn       = ad;
        bus.iKeyValid        = kv;
        bus.iKeyCode         = kc;

        e.pend = m_pend;
        e.ovf  = m_ovf;
        e.stv  = m_stv;
        if (awe) begin
            e.we = 1; e.addr = aa; e.data = ad;
        end else if (m_busy && !r) begin
            e.we = 1;
            if (!m_head) begin
                e.addr = 8'(int'(BASE) + m_ptr);
                e.data = {8'h00, mq[0]};
            end else begin
                e.addr = HEAD;
                e.data = 16'((m_ptr + 1) % RING);
            end
        end else begin
            e.we = 0; e.addr = '0; e.data = '0;
        end
        exp_q.push_back(e);

        if (r) begin
            mq.delete();
            m_busy = 0; m_head = 0; m_ovf = 0; m_stv = 0; m_pend = 0;
            m_ptr = 0; m_cnt = 0;
        end else begin
            granted = m_busy && !awe;
            if (m_busy && awe) begin
                if (m_cnt < LIMIT) m_cnt++;
                if (m_cnt == LIMIT) m_stv = 1;
            end
            if (granted) m_cnt = 0;
            nb = m_busy;
            nh = m_head;
            if (!m_busy) begin
                nb = (mq.size() > 0);
            end else if (granted) begin
                if (!m_head) begin
                    void'(mq.pop_front());
                    nh = 1;
                end else begin
                    m_ptr = (m_ptr + 1) % RING;
                    nh = 0;
                    nb = (mq.size() > 0);
                end
            end
            if (kv) begin
                if (mq.size() < DEPTH) mq.push_back(kc);
                else                   m_ovf = 1;
            end
            m_busy = nb;
            m_head = nh;
            m_pend = m_busy || (mq.size() > 0);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 8'($urandom), 16'($urandom), 0, 8'($urandom));
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests++;
            if ({bus.oWriteEnable, bus.oWriteAddress, bus.oDataOut} !== {e.we, e.addr, e.data}) begin
                fails++;
                $display("FAIL write_port t=%0t got we=%b addr=%h data=%h expected we=%b addr=%h data=%h",
                         $time, bus.oWriteEnable, bus.oWriteAddress, bus.oDataOut, e.we, e.addr, e.data);
            end
            tests++;
            if ({bus.oKeyPending, bus.oOverflow, bus.oStarved} !== {e.pend, e.ovf, e.stv}) begin
                fails++;
                $display("FAIL flags t=%0t got pend/ovf/stv=%b%b%b expected %b%b%b",
                         $time, bus.oKeyPending, bus.oOverflow, bus.oStarved, e.pend, e.ovf, e.stv);
            end
        end
    end

    initial begin
        bus.iAluWriteEnable  = 0;
        bus.iAluWriteAddress = '0;
        bus.iAluDataIn       = '0;
        bus.iKeyValid        = 0;
        bus.iKeyCode         = '0;
        @(posedge clk);

        // Reset values, then a single code with the ALU idle.
        cycle(1, 0, 8'h00, 16'h0000, 0, 8'h00);
        cycle(1, 0, 8'h00, 16'h0000, 0, 8'h00);
        cycle(0, 0, 8'h00, 16'h0000, 1, 8'h1C);
        idle(6);

        // ALU holds the port for 3 cycles across the key sequence.
        cycle(0, 0, 8'h00, 16'h0000, 1, 8'h2A);
        for (int i = 0; i < 3; i++) cycle(0, 1, 8'h05, 16'h1234, 0, 8'h00);
        idle(5);

        // Overflow: five pulses while the ALU writes continuously.
        cycle(1, 0, 8'h00, 16'h0000, 0, 8'h00);
        for (int i = 0; i < 5; i++) cycle(0, 1, 8'(8'h40 + i), 16'($urandom), 1, 8'(8'h30 + i));
        for (int i = 0; i < 3; i++) cycle(0, 1, 8'h11, 16'($urandom), 0, 8'h00);
        idle(12);

        // Nine codes with the ALU idle wrap the ring.
        cycle(1, 0, 8'h00, 16'h0000, 0, 8'h00);
        for (int i = 0; i < 9; i++) begin
            cycle(0, 0, 8'h00, 16'h0000, 1, 8'(8'h60 + i));
            idle(1);
        end
        idle(6);

        // Starvation: key pending while the ALU writes for 18 cycles.
        cycle(1, 0, 8'h00, 16'h0000, 0, 8'h00);
        cycle(0, 0, 8'h00, 16'h0000, 1, 8'h77);
        for (int i = 0; i < 18; i++) cycle(0, 1, 8'(i), 16'($urandom), 0, 8'h00);
        idle(6);

        // Reset between the code write and the head write.
        cycle(1, 0, 8'h00, 16'h0000, 0, 8'h00);
        cycle(0, 0, 8'h00, 16'h0000, 1, 8'h5A);
        idle(2);
        cycle(1, 0, 8'h00, 16'h0000, 0, 8'h00);
        cycle(0, 0, 8'h00, 16'h0000, 1, 8'h5B);
        idle(5);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 45),
                  8'($urandom), 16'($urandom), ($urandom_range(0, 99) < 30), 8'($urandom));
        end
        idle(8);

        repeat (2) @(posedge clk);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain got %0d entries left expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
